regfile_sequencer: RTL and testbench

- Multi-cycle control FSM between the instruction decoder and register_file_r / data memory.
- Accepts one decoded register-file operation at a time and drives reg_op, reg_src, reg_dst, instr_o, loadEn and storEn.
- Runs the data-memory request/acknowledge handshake for loads and stores, and stalls the program counter while busy.
- Single-cycle register operations pass straight through; loads and stores take multiple cycles, with a bounded memory timeout.

---
 rtl/instr_pack.sv | 25 ++
 rtl/regfile_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_pack.sv
// Shared decode types: register-file operations, register names and sequencer states.
// REG_NOP sits outside the decoded range so register_file_r falls into its default (othr) branch.
package instr_pack;

    typedef enum logic [3:0] {
        addEn   = 4'd0,
        subEn   = 4'd1,
        andEn   = 4'd2,
        orEn    = 4'd3,
        xorEn   = 4'd4,
        movEn   = 4'd5,
        j2sr    = 4'd6,
        rFsr    = 4'd7,
        REG_NOP = 4'hF
    } reg_OP;

    typedef enum logic [2:0] {
        rega, regb, regc, regd, regx, regy, regz, regr
    } register;

    typedef enum logic [1:0] {
        IDLE, MREQ, WB
    } seq_state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Decoder-to-register-file sequencer: plain ops 1 cycle, loads >=3, stores >=2, bounded mem wait.
// Backpressure: dec_ready only in IDLE; stall holds the PC for the whole memory transaction.
module regfile_sequencer
    import instr_pack::*;
#(
    parameter int MEM_TIMEOUT = 8,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              start,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  reg_OP             dec_op,
    input  register           dec_src,
    input  register           dec_dst,
    input  logic [3:0]        dec_imm,
    input  logic              dec_load,
    input  logic              dec_store,
    input  logic [ADDR_W-1:0] dec_addr,
    output reg_OP             reg_op,
    output register           reg_src,
    output register           reg_dst,
    output logic [3:0]        instr_o,
    output logic              loadEn,
    output logic              storEn,
    output logic [7:0]        loadData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              stall,
    output logic              mem_err
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

    seq_state_t        state_q, state_d;
    reg_OP             reg_op_q, reg_op_d;
    register           reg_src_q, reg_src_d, reg_dst_q, reg_dst_d;
    register           lat_src_q, lat_src_d, lat_dst_q, lat_dst_d;
    logic [3:0]        instr_q, instr_d;
    logic              load_en_q, load_en_d, stor_en_q, stor_en_d;
    logic [7:0]        load_data_q, load_data_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              stall_q, stall_d, mem_err_q, mem_err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept;

    assign dec_ready = (state_q == IDLE);
    assign accept    = dec_valid && dec_ready;

    always_comb begin
        state_d     = state_q;
        reg_op_d    = REG_NOP;
        reg_src_d   = regr;
        reg_dst_d   = regr;
        instr_d     = 4'd0;
        load_en_d   = 1'b0;
        stor_en_d   = 1'b0;
        load_data_d = load_data_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        stall_d     = 1'b0;
        mem_err_d   = mem_err_q;
        cnt_d       = cnt_q;
        lat_src_d   = lat_src_q;
        lat_dst_d   = lat_dst_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_load || dec_store) begin
                        // load+store together is illegal: run it as a load and flag it
                        state_d    = MREQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = !dec_load;
                        mem_addr_d = dec_addr;
                        stall_d    = 1'b1;
                        cnt_d      = 4'd0;
                        lat_src_d  = dec_src;
                        lat_dst_d  = dec_dst;
                        if (!dec_load) begin
                            stor_en_d = 1'b1;
                            reg_src_d = dec_src;
                        end
                        if (dec_load && dec_store)
                            mem_err_d = 1'b1;
                    end else begin
                        reg_op_d  = dec_op;
                        reg_src_d = dec_src;
                        reg_dst_d = dec_dst;
                        instr_d   = dec_imm;
                    end
                end
            end
            MREQ: begin
                if (mem_ack) begin
                    cnt_d = 4'd0;
                    if (!mem_we_q) begin
                        state_d     = WB;
                        load_data_d = mem_rdata;
                        load_en_d   = 1'b1;
                        reg_dst_d   = lat_dst_q;
                        stall_d     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                    cnt_d     = 4'd0;
                end else begin
                    mem_req_d = 1'b1;
                    stall_d   = 1'b1;
                    cnt_d     = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    if (mem_we_q) begin
                        stor_en_d = 1'b1;
                        reg_src_d = lat_src_q;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            state_q     <= IDLE;
            reg_op_q    <= REG_NOP;
            reg_src_q   <= regr;
            reg_dst_q   <= regr;
            lat_src_q   <= regr;
            lat_dst_q   <= regr;
            instr_q     <= 4'd0;
            load_en_q   <= 1'b0;
            stor_en_q   <= 1'b0;
            load_data_q <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            stall_q     <= 1'b0;
            mem_err_q   <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            reg_op_q    <= reg_op_d;
            reg_src_q   <= reg_src_d;
            reg_dst_q   <= reg_dst_d;
            lat_src_q   <= lat_src_d;
            lat_dst_q   <= lat_dst_d;
            instr_q     <= instr_d;
            load_en_q   <= load_en_d;
            stor_en_q   <= stor_en_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            stall_q     <= stall_d;
            mem_err_q   <= mem_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign reg_op   = reg_op_q;
    assign reg_src  = reg_src_q;
    assign reg_dst  = reg_dst_q;
    assign instr_o  = instr_q;
    assign loadEn   = load_en_q;
    assign storEn   = stor_en_q;
    assign loadData = load_data_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign stall    = stall_q;
    assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Transaction-level bench for regfile_sequencer: directed cases, random op stream, reset abort.
module tb_regfile_sequencer;
    import instr_pack::*;

    localparam int TO = 8;
    localparam int AW = 8;

    logic          clk;
    logic          start;
    logic          dec_valid, dec_ready;
    reg_OP         dec_op, reg_op;
    register       dec_src, dec_dst, reg_src, reg_dst;
    logic [3:0]    dec_imm, instr_o;
    logic          dec_load, dec_store;
    logic [AW-1:0] dec_addr, mem_addr;
    logic          loadEn, storEn;
    logic [7:0]    loadData, mem_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic          stall, mem_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit err_m = 0;

    regfile_sequencer #(.MEM_TIMEOUT(TO), .ADDR_W(AW)) dut (
        .clk(clk), .start(start),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_op(dec_op), .dec_src(dec_src), .dec_dst(dec_dst), .dec_imm(dec_imm),
        .dec_load(dec_load), .dec_store(dec_store), .dec_addr(dec_addr),
        .reg_op(reg_op), .reg_src(reg_src), .reg_dst(reg_dst), .instr_o(instr_o),
        .loadEn(loadEn), .storEn(storEn), .loadData(loadData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_op(input reg_OP op, input register src, input register dst,
                            input logic [3:0] imm, input bit ld, input bit st,
                            input logic [AW-1:0] addr);
        dec_valid = 1'b1;
        dec_op    = op;
        dec_src   = src;
        dec_dst   = dst;
        dec_imm   = imm;
        dec_load  = ld;
        dec_store = st;
        dec_addr  = addr;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_ready"}, 32'(dec_ready), 1);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_lden"}, 32'(loadEn), 0);
        chk({tag, "_sten"}, 32'(storEn), 0);
        chk({tag, "_err"}, 32'(mem_err), 32'(err_m));
    endtask

    // Called at a negedge with the DUT idle; returns at the next idle negedge.
    task automatic run_plain(input reg_OP op, input register src, input register dst,
                             input logic [3:0] imm);
        chk("pl_ready0", 32'(dec_ready), 1);
        drive_op(op, src, dst, imm, 1'b0, 1'b0, '0);
        step();
        dec_valid = 1'b0;
        chk("pl_op", 32'(reg_op), 32'(op));
        chk("pl_src", 32'(reg_src), 32'(src));
        chk("pl_dst", 32'(reg_dst), 32'(dst));
        chk("pl_imm", 32'(instr_o), 32'(imm));
        chk("pl_stall", 32'(stall), 0);
        chk("pl_req", 32'(mem_req), 0);
        step();
        chk("pl_nop", 32'(reg_op), 32'(REG_NOP));
        idle_checks("pl_idle");
    endtask

    // kind: 1 load, 2 store, 3 load+store (illegal). ack_at >= TO means no ack at all.
    task automatic run_mem(input int kind, input register src, input register dst,
                           input logic [AW-1:0] addr, input int ack_at,
                           input logic [7:0] rdata, input bit hold);
        bit is_load = (kind != 2);
        bit acked   = (ack_at < TO);
        int n_req   = acked ? ack_at + 1 : TO;
        chk("m_ready0", 32'(dec_ready), 1);
        drive_op(movEn, src, dst, 4'h3, kind != 2, kind != 1, addr);
        step();
        if (kind == 3) err_m = 1;
        if (hold)
            drive_op(reg_OP'($urandom_range(0, 7)), register'($urandom_range(0, 7)),
                     register'($urandom_range(0, 7)), 4'($urandom), 1'b0, 1'b0, '0);
        else
            dec_valid = 1'b0;
        for (int i = 0; i < n_req; i++) begin
            chk("m_req", 32'(mem_req), 1);
            chk("m_addr", 32'(mem_addr), 32'(addr));
            chk("m_we", 32'(mem_we), 32'(!is_load));
            chk("m_stall", 32'(stall), 1);
            chk("m_ready", 32'(dec_ready), 0);
            chk("m_nop", 32'(reg_op), 32'(REG_NOP));
            chk("m_lden", 32'(loadEn), 0);
            chk("m_sten", 32'(storEn), 32'(!is_load));
            if (!is_load) chk("m_src", 32'(reg_src), 32'(src));
            mem_ack   = (i == ack_at);
            mem_rdata = (i == ack_at) ? rdata : 8'($urandom);
            step();
            mem_ack = 1'b0;
        end
        if (!acked) err_m = 1;
        if (is_load && acked) begin
            chk("wb_lden", 32'(loadEn), 1);
            chk("wb_dst", 32'(reg_dst), 32'(dst));
            chk("wb_data", 32'(loadData), 32'(rdata));
            chk("wb_stall", 32'(stall), 1);
            chk("wb_req", 32'(mem_req), 0);
            chk("wb_ready", 32'(dec_ready), 0);
            step();
        end
        chk("m_idle_nop", 32'(reg_op), 32'(REG_NOP));
        idle_checks("m_idle");
    endtask

    initial begin
        start = 1'b1; dec_valid = 1'b0; dec_op = addEn; dec_src = rega; dec_dst = rega;
        dec_imm = 4'd0; dec_load = 1'b0; dec_store = 1'b0; dec_addr = '0;
        mem_ack = 1'b0; mem_rdata = 8'd0;
        @(negedge clk);
        step();
        chk("rst_op", 32'(reg_op), 32'(REG_NOP));
        chk("rst_src", 32'(reg_src), 32'(regr));
        chk("rst_dst", 32'(reg_dst), 32'(regr));
        chk("rst_imm", 32'(instr_o), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data", 32'(loadData), 0);
        idle_checks("rst");
        start = 1'b0;

        // Directed cases
        run_plain(movEn, regx, rega, 4'h9);
        run_mem(1, regb, regc, 8'h40, 1, 8'hA5, 1'b0);
        run_mem(2, regy, regb, 8'h10, 0, 8'h00, 1'b0);
        run_mem(1, regb, regd, 8'h22, TO - 1, 8'h5C, 1'b0);
        run_mem(2, regz, regb, 8'h33, TO - 1, 8'h00, 1'b1);
        run_plain(j2sr, regr, regr, 4'hF);
        run_mem(1, rega, regc, 8'h77, 0, 8'h3C, 1'b1);
        run_plain(rFsr, regd, regz, 4'h1);
        run_mem(1, rega, regb, 8'h01, TO + 3, 8'h00, 1'b1);

        // Random op stream
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 9);
            if (r < 4)
                run_plain(reg_OP'($urandom_range(0, 7)), register'($urandom_range(0, 7)),
                          register'($urandom_range(0, 7)), 4'($urandom));
            else
                run_mem((r < 7) ? 1 : (r < 9) ? 2 : 3,
                        register'($urandom_range(0, 7)), register'($urandom_range(0, 7)),
                        8'($urandom), $urandom_range(0, TO + 1), 8'($urandom),
                        1'($urandom));
        end
        run_mem(3, rega, regd, 8'hE0, 2, 8'h96, 1'b0);

        // Reset in the middle of a load request abandons it; a late ack is ignored
        chk("ra_ready0", 32'(dec_ready), 1);
        drive_op(addEn, rega, regb, 4'h0, 1'b1, 1'b0, 8'h55);
        step();
        dec_valid = 1'b0;
        step();
        chk("ra_req_pre", 32'(mem_req), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        err_m = 0;
        chk("ra_req", 32'(mem_req), 0);
        chk("ra_nop", 32'(reg_op), 32'(REG_NOP));
        idle_checks("ra");
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
        step();
        mem_ack = 1'b0;
        chk("ra_late_lden", 32'(loadEn), 0);
        chk("ra_late_data", 32'(loadData), 0);
        idle_checks("ra_late");
        run_plain(orEn, regc, regd, 4'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
